mem_access_unit: RTL and testbench

//   Initiator side of the 32x32 byte-select data RAM: turns CPU load/store requests
//   (byte address, size, signedness) into RAM word address, byte-select, write data.

---
 rtl/mem_access_unit.sv | 159 +++++++++++++++
 tb/tb_mem_access_unit.sv | 369 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - CPU load/store to byte-select word RAM access unit with straddle split
module mem_access_unit #(
   parameter int WORDS_LOG2 = 5
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_we,
   input  logic [1:0]            req_size,
   input  logic                  req_signed,
   input  logic [WORDS_LOG2+1:0] req_addr,
   input  logic [31:0]           req_wdata,
   output logic                  resp_valid,
   output logic [31:0]           resp_rdata,
   output logic [WORDS_LOG2-1:0] ram_addr,
   output logic [31:0]           ram_din,
   output logic                  ram_we,
   output logic [3:0]            ram_sel,
   input  logic [31:0]           ram_dout
);

   localparam int AW = WORDS_LOG2 + 2;

   typedef enum logic [1:0] {IDLE, ACC0, ACC1, RESP} state_t;

   state_t      state;
   logic        l_we;
   logic [1:0]  l_size;
   logic        l_signed;
   logic [1:0]  l_off;
   logic [3:0]  l_sel_hi;
   logic [31:0] l_din_hi;
   logic [31:0] buf0;
   logic [31:0] buf1;
   logic [31:0] rdata_q;

   // Two-word lane mask: low nibble is word w, high nibble is word w+1.
   function automatic logic [7:0] lane_mask(input logic [1:0] size, input logic [1:0] off);
      logic [7:0] base;
      case (size)
         2'b00:   base = 8'h01;
         2'b01:   base = 8'h03;
         default: base = 8'h0F;
      endcase
      return base << off;
   endfunction

   // Store data masked to the access width and shifted onto its byte lanes.
   function automatic logic [63:0] lane_data(input logic [1:0] size, input logic [1:0] off,
                                             input logic [31:0] wdata);
      logic [31:0] m;
      case (size)
         2'b00:   m = {24'b0, wdata[7:0]};
         2'b01:   m = {16'b0, wdata[15:0]};
         default: m = wdata;
      endcase
      return {32'b0, m} << {off, 3'b000};
   endfunction

   // Pull the addressed bytes out of the word pair and extend them to 32 bits.
   function automatic logic [31:0] load_extend(input logic [1:0] size, input logic sgn,
                                               input logic [1:0] off, input logic [63:0] pair);
      logic [31:0] sh;
      logic [31:0] r;
      sh = 32'(pair >> {off, 3'b000});
      case (size)
         2'b00:   r = {{24{sgn & sh[7]}}, sh[7:0]};
         2'b01:   r = {{16{sgn & sh[15]}}, sh[15:0]};
         default: r = sh;
      endcase
      return r;
   endfunction

   logic [7:0]  req_mask;
   logic [63:0] req_lanes;

   // Lane mask and aligned data for the incoming request, registered on acceptance.
   always_comb begin
      req_mask  = lane_mask(req_size, req_addr[1:0]);
      req_lanes = lane_data(req_size, req_addr[1:0], req_wdata);
   end

   // The extended load value is live during RESP and then held until the next load.
   assign resp_rdata = (state == RESP && !l_we) ? load_extend(l_size, l_signed, l_off, {buf1, buf0})
                                                : rdata_q;

   // Access sequencer: RAM-facing outputs are registered so each state drives them cleanly.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         req_ready  <= 1'b1;
         resp_valid <= 1'b0;
         ram_addr   <= '0;
         ram_din    <= '0;
         ram_we     <= 1'b0;
         ram_sel    <= '0;
         l_we       <= 1'b0;
         l_size     <= '0;
         l_signed   <= 1'b0;
         l_off      <= '0;
         l_sel_hi   <= '0;
         l_din_hi   <= '0;
         buf0       <= '0;
         buf1       <= '0;
         rdata_q    <= '0;
      end else begin
         case (state)
            IDLE: begin
               resp_valid <= 1'b0;
               if (req_valid) begin
                  l_we      <= req_we;
                  l_size    <= req_size;
                  l_signed  <= req_signed;
                  l_off     <= req_addr[1:0];
                  l_sel_hi  <= req_mask[7:4];
                  l_din_hi  <= req_lanes[63:32];
                  buf1      <= '0;
                  ram_addr  <= req_addr[AW-1:2];
                  ram_sel   <= req_mask[3:0];
                  ram_din   <= req_lanes[31:0];
                  ram_we    <= req_we;
                  req_ready <= 1'b0;
                  state     <= ACC0;
               end
            end
            ACC0: begin
               if (!l_we) buf0 <= ram_dout;
               if (|l_sel_hi) begin
                  // Second word wraps naturally at the top of the RAM.
                  ram_addr <= ram_addr + 1'b1;
                  ram_sel  <= l_sel_hi;
                  ram_din  <= l_din_hi;
                  state    <= ACC1;
               end else begin
                  ram_sel    <= '0;
                  ram_we     <= 1'b0;
                  resp_valid <= 1'b1;
                  state      <= RESP;
               end
            end
            ACC1: begin
               if (!l_we) buf1 <= ram_dout;
               ram_sel    <= '0;
               ram_we     <= 1'b0;
               resp_valid <= 1'b1;
               state      <= RESP;
            end
            default: begin
               if (!l_we) rdata_q <= load_extend(l_size, l_signed, l_off, {buf1, buf0});
               resp_valid <= 1'b0;
               req_ready  <= 1'b1;
               state      <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - self-checking bench for mem_access_unit with byte-array reference
module tb_mem_access_unit;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [1:0]  req_size;
   logic        req_signed;
   logic [6:0]  req_addr;
   logic [31:0] req_wdata;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic [4:0]  ram_addr;
   logic [31:0] ram_din;
   logic        ram_we;
   logic [3:0]  ram_sel;
   logic [31:0] ram_dout;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   mem_access_unit #(.WORDS_LOG2(5)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
      .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
      .ram_addr(ram_addr), .ram_din(ram_din), .ram_we(ram_we), .ram_sel(ram_sel),
      .ram_dout(ram_dout)
   );

   // RAM: combinational read, byte-lane write on the clock edge
   logic [31:0] ram_mem [32];
   assign ram_dout = ram_mem[ram_addr];
   always @(posedge clk) begin
      if (ram_we)
         for (int b = 0; b < 4; b++)
            if (ram_sel[b]) ram_mem[ram_addr][8*b +: 8] <= ram_din[8*b +: 8];
   end

   // Reference: flat little-endian byte memory, addresses wrap mod 128
   logic [7:0] refmem [128];

   function automatic int nbytes(input logic [1:0] sz);
      return (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
   endfunction

   function automatic logic [31:0] ref_load(input logic [6:0] addr, input logic [1:0] sz,
                                            input logic sgn);
      logic [31:0] r;
      int n;
      r = 0;
      n = nbytes(sz);
      for (int i = 0; i < n; i++) r[8*i +: 8] = refmem[(int'(addr) + i) % 128];
      if (sgn && n == 1 && r[7])  r[31:8]  = '1;
      if (sgn && n == 2 && r[15]) r[31:16] = '1;
      return r;
   endfunction

   task automatic ref_store(input logic [6:0] addr, input logic [1:0] sz, input logic [31:0] wd);
      for (int i = 0; i < nbytes(sz); i++) refmem[(int'(addr) + i) % 128] = wd[8*i +: 8];
   endtask

   // Observations of the last access
   logic [4:0]  o_a0, o_a1;
   logic [3:0]  o_s0, o_s1, o_sel_resp;
   logic [31:0] o_d0, o_d1, o_rdata;
   logic        o_w0, o_w1, o_rdy0, o_we_resp, o_pulse2;
   int          o_lat;

   // One request; o_lat counts edges after the accepting edge until resp_valid
   // (1 = response in cycle N+2, 2 = cycle N+3, 0 = no response within budget)
   task automatic access(input logic we, input logic [1:0] sz, input logic sgn,
                         input logic [6:0] addr, input logic [31:0] wd);
      int guard;
      @(negedge clk);
      guard = 0;
      while (!req_ready && guard < 20) begin
         @(negedge clk);
         guard++;
      end
      req_we = we; req_size = sz; req_signed = sgn; req_addr = addr; req_wdata = wd;
      req_valid = 1'b1;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      o_a0 = ram_addr; o_s0 = ram_sel; o_d0 = ram_din; o_w0 = ram_we; o_rdy0 = req_ready;
      o_a1 = 0; o_s1 = 0; o_d1 = 0; o_w1 = 0; o_lat = 0; o_rdata = 0;
      o_sel_resp = 0; o_we_resp = 0;
      for (int k = 1; k <= 6; k++) begin
         @(posedge clk);
         #1;
         if (resp_valid) begin
            o_lat = k; o_rdata = resp_rdata; o_sel_resp = ram_sel; o_we_resp = ram_we;
            break;
         end
         if (k == 1) begin
            o_a1 = ram_addr; o_s1 = ram_sel; o_d1 = ram_din; o_w1 = ram_we;
         end
      end
      @(posedge clk);
      #1;
      o_pulse2 = resp_valid;
      if (we) ref_store(addr, sz, wd);
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (req_ready !== 1'b1 || resp_valid !== 1'b0 || ram_we !== 1'b0 || ram_sel !== 4'h0 ||
          ram_addr !== 5'h0 || ram_din !== 32'h0 || resp_rdata !== 32'h0) begin
         errors++;
         $display("FAIL reset_state got rdy=%b rv=%b we=%b sel=%h addr=%h din=%h rd=%h want 1 0 0 0 0 0 0",
                  req_ready, resp_valid, ram_we, ram_sel, ram_addr, ram_din, resp_rdata);
      end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_reset_mid_access;
      int pulses;
      @(negedge clk);
      req_we = 1'b1; req_size = 2'b10; req_signed = 1'b0; req_addr = 7'h10; req_wdata = 32'hCAFEF00D;
      req_valid = 1'b1;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      checks++;
      if (ram_we !== 1'b1) begin
         errors++;
         $display("FAIL mid_acc0_we got %b want 1", ram_we);
      end
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if (ram_we !== 1'b0 || ram_sel !== 4'h0 || req_ready !== 1'b1 || resp_valid !== 1'b0) begin
         errors++;
         $display("FAIL async_reset got we=%b sel=%h rdy=%b rv=%b want 0 0 1 0",
                  ram_we, ram_sel, req_ready, resp_valid);
      end
      @(negedge clk);
      rst_n = 1'b1;
      pulses = 0;
      repeat (6) begin
         @(posedge clk);
         #1;
         if (resp_valid) pulses++;
      end
      checks++;
      if (pulses !== 0 || req_ready !== 1'b1) begin
         errors++;
         $display("FAIL abandoned_access got pulses=%0d rdy=%b want 0 1", pulses, req_ready);
      end
   endtask

   task automatic test_aligned_word;
      access(1'b1, 2'b10, 1'b0, 7'h08, 32'hDEADBEEF);
      checks++;
      if (o_a0 !== 5'd2 || o_s0 !== 4'b1111 || o_d0 !== 32'hDEADBEEF || o_w0 !== 1'b1) begin
         errors++;
         $display("FAIL sw_aligned_acc0 got a=%0d sel=%b din=%h we=%b want 2 1111 deadbeef 1",
                  o_a0, o_s0, o_d0, o_w0);
      end
      checks++;
      if (o_lat !== 1 || o_pulse2 !== 1'b0 || o_rdy0 !== 1'b0 || o_sel_resp !== 4'h0 || o_we_resp !== 1'b0) begin
         errors++;
         $display("FAIL sw_aligned_timing got lat=%0d pulse2=%b rdy=%b sel=%h we=%b want 1 0 0 0 0",
                  o_lat, o_pulse2, o_rdy0, o_sel_resp, o_we_resp);
      end
      access(1'b0, 2'b10, 1'b0, 7'h08, 32'h0);
      checks++;
      if (o_rdata !== 32'hDEADBEEF || o_lat !== 1 || o_w0 !== 1'b0) begin
         errors++;
         $display("FAIL lw_aligned got rd=%h lat=%0d we=%b want deadbeef 1 0", o_rdata, o_lat, o_w0);
      end
   endtask

   task automatic test_byte;
      access(1'b1, 2'b00, 1'b0, 7'h05, 32'h000000A5);
      checks++;
      if (o_a0 !== 5'd1 || o_s0 !== 4'b0010 || o_d0 !== 32'h0000A500) begin
         errors++;
         $display("FAIL sb got a=%0d sel=%b din=%h want 1 0010 0000a500", o_a0, o_s0, o_d0);
      end
      access(1'b0, 2'b00, 1'b1, 7'h05, 32'h0);
      checks++;
      if (o_rdata !== 32'hFFFFFFA5) begin
         errors++;
         $display("FAIL lb_signed got %h want ffffffa5", o_rdata);
      end
      access(1'b0, 2'b00, 1'b0, 7'h05, 32'h0);
      checks++;
      if (o_rdata !== 32'h000000A5) begin
         errors++;
         $display("FAIL lbu got %h want 000000a5", o_rdata);
      end
   endtask

   task automatic test_straddle;
      access(1'b1, 2'b10, 1'b0, 7'h0E, 32'h11223344);
      checks++;
      if (o_a0 !== 5'd3 || o_s0 !== 4'b1100 || o_d0 !== 32'h33440000 || o_w0 !== 1'b1) begin
         errors++;
         $display("FAIL sw_straddle_acc0 got a=%0d sel=%b din=%h we=%b want 3 1100 33440000 1",
                  o_a0, o_s0, o_d0, o_w0);
      end
      checks++;
      if (o_a1 !== 5'd4 || o_s1 !== 4'b0011 || o_d1 !== 32'h00001122 || o_w1 !== 1'b1 || o_lat !== 2) begin
         errors++;
         $display("FAIL sw_straddle_acc1 got a=%0d sel=%b din=%h we=%b lat=%0d want 4 0011 00001122 1 2",
                  o_a1, o_s1, o_d1, o_w1, o_lat);
      end
      access(1'b0, 2'b10, 1'b0, 7'h0E, 32'h0);
      checks++;
      if (o_rdata !== 32'h11223344 || o_lat !== 2 || o_pulse2 !== 1'b0) begin
         errors++;
         $display("FAIL lw_straddle got rd=%h lat=%0d pulse2=%b want 11223344 2 0", o_rdata, o_lat, o_pulse2);
      end
   endtask

   task automatic test_wrap;
      access(1'b1, 2'b01, 1'b0, 7'h7F, 32'h00008001);
      checks++;
      if (o_a0 !== 5'd31 || o_s0 !== 4'b1000 || o_d0 !== 32'h01000000 ||
          o_a1 !== 5'd0 || o_s1 !== 4'b0001 || o_d1 !== 32'h00000080) begin
         errors++;
         $display("FAIL sh_wrap got a0=%0d s0=%b d0=%h a1=%0d s1=%b d1=%h want 31 1000 01000000 0 0001 00000080",
                  o_a0, o_s0, o_d0, o_a1, o_s1, o_d1);
      end
      access(1'b0, 2'b01, 1'b1, 7'h7F, 32'h0);
      checks++;
      if (o_rdata !== 32'hFFFF8001 || o_lat !== 2) begin
         errors++;
         $display("FAIL lh_wrap got rd=%h lat=%0d want ffff8001 2", o_rdata, o_lat);
      end
   endtask

   task automatic test_random;
      logic        we, sgn;
      logic [1:0]  sz;
      logic [6:0]  addr;
      logic [31:0] wd, exp_rd;
      int          n, exp_lat;
      for (int it = 0; it < 80; it++) begin
         we   = 1'($urandom_range(0, 1));
         sz   = 2'($urandom_range(0, 3));
         sgn  = 1'($urandom_range(0, 1));
         addr = 7'($urandom_range(0, 127));
         wd   = $urandom;
         n    = nbytes(sz);
         exp_lat = ((int'(addr) % 4) + n > 4) ? 2 : 1;
         exp_rd  = ref_load(addr, sz, sgn);
         access(we, sz, sgn, addr, wd);
         checks++;
         if (o_lat !== exp_lat || o_w0 !== we || o_a0 !== addr[6:2] ||
             ($countones(o_s0) + $countones(o_s1)) !== n) begin
            errors++;
            $display("FAIL rand_access it=%0d got lat=%0d we=%b a0=%0d lanes=%0d want %0d %b %0d %0d",
                     it, o_lat, o_w0, o_a0, $countones(o_s0) + $countones(o_s1),
                     exp_lat, we, addr[6:2], n);
         end
         if (exp_lat == 2) begin
            checks++;
            if (o_a1 !== 5'(addr[6:2] + 5'd1)) begin
               errors++;
               $display("FAIL rand_acc1_addr it=%0d got %0d want %0d", it, o_a1, 5'(addr[6:2] + 5'd1));
            end
         end
         if (!we) begin
            checks++;
            if (o_rdata !== exp_rd) begin
               errors++;
               $display("FAIL rand_load it=%0d addr=%h sz=%0d sgn=%b got %h want %h",
                        it, addr, sz, sgn, o_rdata, exp_rd);
            end
         end
      end
   endtask

   task automatic test_back_to_back;
      logic [6:0]  la [3];
      logic [1:0]  ls [3];
      logic        lg [3];
      logic [31:0] expq [$];
      logic [31:0] got;
      int idx, nresp;
      logic acc;
      la[0] = 7'h20; ls[0] = 2'b10; lg[0] = 1'b0;
      la[1] = 7'h33; ls[1] = 2'b01; lg[1] = 1'b1;
      la[2] = 7'h46; ls[2] = 2'b00; lg[2] = 1'b1;
      access(1'b1, 2'b10, 1'b0, 7'h20, 32'hA1B2C3D4);
      access(1'b1, 2'b10, 1'b0, 7'h30, 32'h8F00_1234);
      access(1'b1, 2'b10, 1'b0, 7'h44, 32'h00F70000);
      for (int i = 0; i < 3; i++) expq.push_back(ref_load(la[i], ls[i], lg[i]));
      idx = 0;
      nresp = 0;
      @(negedge clk);
      for (int cyc = 0; cyc < 25; cyc++) begin
         if (idx < 3) begin
            req_we = 1'b0; req_addr = la[idx]; req_size = ls[idx]; req_signed = lg[idx];
            req_wdata = 32'h0; req_valid = 1'b1;
         end else begin
            req_valid = 1'b0;
         end
         acc = req_valid && req_ready;
         @(posedge clk);
         #1;
         if (acc) begin
            idx++;
            checks++;
            if (req_ready !== 1'b0) begin
               errors++;
               $display("FAIL b2b_busy_ready got %b want 0", req_ready);
            end
         end
         if (resp_valid) begin
            got = resp_rdata;
            checks++;
            if (nresp >= 3) begin
               errors++;
               $display("FAIL b2b_extra_resp got %h want none", got);
            end else if (got !== expq[nresp]) begin
               errors++;
               $display("FAIL b2b_order resp=%0d got %h want %h", nresp, got, expq[nresp]);
            end
            nresp++;
         end
         @(negedge clk);
      end
      req_valid = 1'b0;
      checks++;
      if (nresp !== 3 || idx !== 3) begin
         errors++;
         $display("FAIL b2b_count got resp=%0d acc=%0d want 3 3", nresp, idx);
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog got timeout want finish");
      $fatal(1);
   end

   initial begin
      req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00; req_signed = 1'b0;
      req_addr = 7'h0; req_wdata = 32'h0;
      for (int w = 0; w < 32; w++) begin
         ram_mem[w] = $urandom;
         for (int b = 0; b < 4; b++) refmem[4*w + b] = ram_mem[w][8*b +: 8];
      end
      test_reset;
      test_reset_mid_access;
      test_aligned_word;
      test_byte;
      test_straddle;
      test_wrap;
      test_random;
      test_back_to_back;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
